// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the set-associative write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WB,
    FILL
  } cache_state_t;

  // Line width in bits for a given number of byte-offset bits.
  function automatic int calc_lw(input int s_offset);
    return 8 * (1 << s_offset);
  endfunction

  // Tag width left over after offset and index are removed from a 32-bit address.
  function automatic int calc_tagw(input int s_offset, input int s_index);
    return 32 - s_offset - s_index;
  endfunction

  // Depth of the PLRU tree; a direct-mapped cache has no tree at all.
  function automatic int plru_levels(input int ways);
    return (ways > 1) ? $clog2(ways) : 0;
  endfunction

  // Storage bits per set for the PLRU tree, kept at least 1 so vectors stay legal.
  function automatic int plru_bits(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  // Width of a way number, at least 1.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  function automatic int plru_child(input int node, input logic dir);
    return 2 * node + 1 + int'(dir);
  endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Combinational tree pseudo-LRU: picks the victim way of a set and computes
// the tree bits after an access to a given way.
module cache_plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [plru_bits(WAYS)-1:0] plru_cur,
  input  logic [way_bits(WAYS)-1:0]  access_way,
  output logic [way_bits(WAYS)-1:0]  victim_way,
  output logic [plru_bits(WAYS)-1:0] plru_upd
);

  localparam int LEVELS = plru_levels(WAYS);

  // Follow the node bits from the root; each bit names the subtree holding the victim.
  always_comb begin
    int node;
    victim_way = '0;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      victim_way[LEVELS-1-l] = plru_cur[node];
      node = plru_child(node, plru_cur[node]);
    end
  end

  // Walk the accessed way's path and point every node on it at the other subtree.
  always_comb begin
    int   node;
    logic dir;
    plru_upd = plru_cur;
    node = 0;
    dir = 1'b0;
    for (int l = 0; l < LEVELS; l++) begin
      dir = access_way[LEVELS-1-l];
      plru_upd[node] = ~dir;
      node = plru_child(node, dir);
    end
  end

endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back, write-allocate cache with tree PLRU
// replacement and a four-state miss handler (IDLE, CHECK, WB, FILL).
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int WAYS     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_read,
  input  logic                           mem_write,
  input  logic [31:0]                    mem_address,
  input  logic [(1 << S_OFFSET)-1:0]     mem_byte_enable,
  input  logic [calc_lw(S_OFFSET)-1:0]   mem_wdata,
  output logic [calc_lw(S_OFFSET)-1:0]   mem_rdata,
  output logic                           mem_resp,
  output logic                           pmem_read,
  output logic                           pmem_write,
  output logic [31:0]                    pmem_address,
  output logic [calc_lw(S_OFFSET)-1:0]   pmem_wdata,
  input  logic [calc_lw(S_OFFSET)-1:0]   pmem_rdata,
  input  logic                           pmem_resp
);

  localparam int LW   = calc_lw(S_OFFSET);
  localparam int BEW  = 1 << S_OFFSET;
  localparam int TAGW = calc_tagw(S_OFFSET, S_INDEX);
  localparam int SETS = 1 << S_INDEX;
  localparam int NB   = plru_bits(WAYS);
  localparam int WAYW = way_bits(WAYS);

  cache_state_t state_q, state_d;

  logic [WAYS-1:0][SETS-1:0][LW-1:0]   data_q;
  logic [WAYS-1:0][SETS-1:0][TAGW-1:0] tag_q;
  logic [WAYS-1:0][SETS-1:0]           valid_q;
  logic [WAYS-1:0][SETS-1:0]           dirty_q;
  logic [SETS-1:0][NB-1:0]             plru_q;
  logic [WAYW-1:0]                     victim_q;

  logic [TAGW-1:0]    req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [WAYS-1:0]    hit_vec;
  logic               hit;
  logic [WAYW-1:0]    hit_way;
  logic               inv_found;
  logic [WAYW-1:0]    inv_way;
  logic [WAYW-1:0]    plru_victim;
  logic [WAYW-1:0]    miss_victim;
  logic [NB-1:0]      plru_next;
  logic               unused_offset;

  assign req_tag       = mem_address[31:S_OFFSET+S_INDEX];
  assign req_index     = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign unused_offset = ^mem_address[S_OFFSET-1:0];

  cache_plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_cur   (plru_q[req_index]),
    .access_way (hit_way),
    .victim_way (plru_victim),
    .plru_upd   (plru_next)
  );

  // Tag compare across the set, plus the lowest-numbered invalid way as preferred victim.
  always_comb begin
    hit_vec   = '0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[w][req_index] && (tag_q[w][req_index] == req_tag);
      if (hit_vec[w]) hit_way = WAYW'(w);
      if (!valid_q[w][req_index]) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
    hit         = |hit_vec;
    miss_victim = inv_found ? inv_way : plru_victim;
  end

  // Next-state logic and CPU-side response; a hit answers in the CHECK cycle itself.
  always_comb begin
    state_d   = state_q;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    case (state_q)
      IDLE: if (mem_read || mem_write) state_d = CHECK;
      CHECK: begin
        if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = data_q[hit_way][req_index];
          state_d   = IDLE;
        end else if (valid_q[miss_victim][req_index] && dirty_q[miss_victim][req_index]) begin
          state_d = WB;
        end else begin
          state_d = FILL;
        end
      end
      WB:   if (pmem_resp) state_d = FILL;
      FILL: if (pmem_resp) state_d = CHECK;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side strobes and address come only from registered state and stored victim.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = data_q[victim_q][req_index];
    case (state_q)
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][req_index], req_index, {S_OFFSET{1'b0}}};
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Storage: hit writes and PLRU updates in CHECK, victim capture on a miss, line install on fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      tag_q    <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
      victim_q <= '0;
    end else begin
      if (state_q == CHECK && hit) begin
        plru_q[req_index] <= plru_next;
        if (mem_write) begin
          dirty_q[hit_way][req_index] <= 1'b1;
          for (int b = 0; b < BEW; b++) begin
            if (mem_byte_enable[b])
              data_q[hit_way][req_index][8*b +: 8] <= mem_wdata[8*b +: 8];
          end
        end
      end
      if (state_q == CHECK && !hit) victim_q <= miss_victim;
      if (state_q == FILL && pmem_resp) begin
        data_q[victim_q][req_index]  <= pmem_rdata;
        tag_q[victim_q][req_index]   <= req_tag;
        valid_q[victim_q][req_index] <= 1'b1;
        dirty_q[victim_q][req_index] <= 1'b0;
      end
    end
  end

  // A tag may live in at most one way of a set.
  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == CHECK) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb: a 2-way instance and a 4-way instance share
// a behavioural line memory; only one instance is addressed at a time.
module tb_cache_sa_wb;
  import cache_pkg::*;

  localparam int MEM_LAT = 3;
  localparam logic [255:0] LINE_A     = {8{32'hC0DE_0040}};
  localparam logic [255:0] LINE_A_MOD = {{7{32'hC0DE_0040}}, 32'hFFFF_FFFF};

  logic clk, rst, sel, rd, wr;
  logic [31:0]  addr, be;
  logic [255:0] wd;
  logic         presp;
  logic [255:0] prdata;

  logic         mem_resp_a, pmem_read_a, pmem_write_a;
  logic [255:0] mem_rdata_a, pmem_wdata_a;
  logic [31:0]  pmem_address_a;
  logic         mem_resp_b, pmem_read_b, pmem_write_b;
  logic [255:0] mem_rdata_b, pmem_wdata_b;
  logic [31:0]  pmem_address_b;

  logic         act_resp, act_pread, act_pwrite;
  logic [255:0] act_rdata, act_pwdata;
  logic [31:0]  act_paddr;

  int total = 0, bad = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, overlap = 0;
  int last_resp_cyc = 0, last_wr_cyc = 0, last_rd_cyc = 0, resp_cyc = 0;
  logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [255:0] last_wr_data = '0;
  bit mem_hold = 0;
  logic [255:0] mem [logic [31:0]];

  cache_sa_wb dut_a (
    .clk(clk), .rst(rst), .mem_read(rd & ~sel), .mem_write(wr & ~sel),
    .mem_address(addr), .mem_byte_enable(be), .mem_wdata(wd),
    .mem_rdata(mem_rdata_a), .mem_resp(mem_resp_a),
    .pmem_read(pmem_read_a), .pmem_write(pmem_write_a),
    .pmem_address(pmem_address_a), .pmem_wdata(pmem_wdata_a),
    .pmem_rdata(prdata), .pmem_resp(presp & ~sel));

  cache_sa_wb #(.WAYS(4)) dut_b (
    .clk(clk), .rst(rst), .mem_read(rd & sel), .mem_write(wr & sel),
    .mem_address(addr), .mem_byte_enable(be), .mem_wdata(wd),
    .mem_rdata(mem_rdata_b), .mem_resp(mem_resp_b),
    .pmem_read(pmem_read_b), .pmem_write(pmem_write_b),
    .pmem_address(pmem_address_b), .pmem_wdata(pmem_wdata_b),
    .pmem_rdata(prdata), .pmem_resp(presp & sel));

  assign act_resp   = sel ? mem_resp_b     : mem_resp_a;
  assign act_rdata  = sel ? mem_rdata_b    : mem_rdata_a;
  assign act_pread  = sel ? pmem_read_b    : pmem_read_a;
  assign act_pwrite = sel ? pmem_write_b   : pmem_write_a;
  assign act_paddr  = sel ? pmem_address_b : pmem_address_a;
  assign act_pwdata = sel ? pmem_wdata_b   : pmem_wdata_a;

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line memory: answers the selected cache MEM_LAT cycles after its strobe rises.
  initial begin : mem_model
    int wait_cnt;
    wait_cnt = 0;
    presp = 1'b0;
    prdata = '0;
    forever begin
      @(negedge clk);
      presp = 1'b0;
      if ((pmem_read_a && pmem_write_a) || (pmem_read_b && pmem_write_b)) overlap++;
      if ((act_pread || act_pwrite) && !mem_hold) begin
        wait_cnt++;
        if (wait_cnt >= MEM_LAT) begin
          wait_cnt = 0;
          if (act_pwrite) begin
            mem[act_paddr] = act_pwdata;
            wr_cnt++;
            last_wr_addr = act_paddr;
            last_wr_data = act_pwdata;
            last_wr_cyc  = cyc;
          end else begin
            prdata = mem.exists(act_paddr) ? mem[act_paddr] : pat(act_paddr);
            rd_cnt++;
            last_rd_addr = act_paddr;
            last_rd_cyc  = cyc;
          end
          presp = 1'b1;
          last_resp_cyc = cyc;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one CPU request starting at a negedge and returns latency, data and pmem activity.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] b,
                        input logic [255:0] d, output int lat, output logic [255:0] rdat,
                        output int drd, output int dwr, output bit ok);
    int rd0, wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    addr = a; be = b; wd = d; wr = w; rd = !w;
    lat = 0; ok = 0; rdat = '0;
    while (lat < 60 && !ok) begin
      @(negedge clk);
      lat++;
      if (act_resp) begin
        ok = 1;
        rdat = act_rdata;
        resp_cyc = cyc;
      end
    end
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    drd = rd_cnt - rd0;
    dwr = wr_cnt - wr0;
  endtask

  task automatic test_reset();
    sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wd = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_resp_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_resp: got %b want 0", mem_resp_a); end
    total++; if (pmem_read_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_pmem_read: got %b want 0", pmem_read_a); end
    total++; if (pmem_write_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_pmem_write: got %b want 0", pmem_write_a); end
    total++; if (mem_rdata_a !== '0) begin bad++; $display("[TB] FAIL reset_mem_rdata: got %h want 0", mem_rdata_a); end
    total++; if (dut_a.state_q !== IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d want IDLE", dut_a.state_q); end
    total++; if (mem_resp_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_resp_b: got %b want 0", mem_resp_b); end
  endtask

  task automatic test_read_miss();
    int lat, drd, dwr; bit ok; logic [255:0] rdat;
    do_req(1'b0, 32'h40, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL miss_timeout: got %b want 1", ok); end
    total++; if (rdat !== LINE_A) begin bad++; $display("[TB] FAIL miss_rdata: got %h want %h", rdat, LINE_A); end
    total++; if (drd !== 1 || dwr !== 0) begin bad++; $display("[TB] FAIL miss_pmem_ops: got rd=%0d wr=%0d want rd=1 wr=0", drd, dwr); end
    total++; if (last_rd_addr !== 32'h40) begin bad++; $display("[TB] FAIL miss_fill_addr: got %h want 00000040", last_rd_addr); end
    total++; if (resp_cyc - last_resp_cyc !== 1) begin bad++; $display("[TB] FAIL miss_resp_gap: got %0d want 1", resp_cyc - last_resp_cyc); end
  endtask

  task automatic test_read_hit();
    int lat, drd, dwr; bit ok; logic [255:0] rdat;
    do_req(1'b0, 32'h40, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL hit_latency: got %0d want 1", lat); end
    total++; if (rdat !== LINE_A) begin bad++; $display("[TB] FAIL hit_rdata: got %h want %h", rdat, LINE_A); end
    total++; if (drd !== 0 || dwr !== 0) begin bad++; $display("[TB] FAIL hit_pmem_ops: got rd=%0d wr=%0d want 0 0", drd, dwr); end
  endtask

  task automatic test_write_hit();
    int lat, drd, dwr; bit ok; logic [255:0] rdat;
    do_req(1'b1, 32'h40, 32'h0000_000F, {256{1'b1}}, lat, rdat, drd, dwr, ok);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL write_latency: got %0d want 1", lat); end
    total++; if (drd !== 0 || dwr !== 0) begin bad++; $display("[TB] FAIL write_pmem_ops: got rd=%0d wr=%0d want 0 0", drd, dwr); end
    do_req(1'b0, 32'h40, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL readback_latency: got %0d want 1", lat); end
    total++; if (rdat !== LINE_A_MOD) begin bad++; $display("[TB] FAIL readback_rdata: got %h want %h", rdat, LINE_A_MOD); end
  endtask

  task automatic test_writeback();
    int lat, drd, dwr; bit ok; logic [255:0] rdat;
    do_req(1'b0, 32'h140, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (drd !== 1 || dwr !== 0) begin bad++; $display("[TB] FAIL fill_way1_ops: got rd=%0d wr=%0d want 1 0", drd, dwr); end
    total++; if (rdat !== pat(32'h140)) begin bad++; $display("[TB] FAIL fill_way1_rdata: got %h want %h", rdat, pat(32'h140)); end
    do_req(1'b0, 32'h240, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (drd !== 1 || dwr !== 1) begin bad++; $display("[TB] FAIL wb_ops: got rd=%0d wr=%0d want 1 1", drd, dwr); end
    total++; if (last_wr_addr !== 32'h40) begin bad++; $display("[TB] FAIL wb_addr: got %h want 00000040", last_wr_addr); end
    total++; if (last_wr_data !== LINE_A_MOD) begin bad++; $display("[TB] FAIL wb_data: got %h want %h", last_wr_data, LINE_A_MOD); end
    total++; if (last_rd_addr !== 32'h240) begin bad++; $display("[TB] FAIL wb_fill_addr: got %h want 00000240", last_rd_addr); end
    total++; if (!(last_wr_cyc < last_rd_cyc)) begin bad++; $display("[TB] FAIL wb_order: got wr@%0d rd@%0d want wr first", last_wr_cyc, last_rd_cyc); end
    total++; if (rdat !== pat(32'h240)) begin bad++; $display("[TB] FAIL wb_rdata: got %h want %h", rdat, pat(32'h240)); end
    total++; if (overlap !== 0) begin bad++; $display("[TB] FAIL strobe_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_ways4();
    int lat, drd, dwr; bit ok; logic [255:0] rdat;
    logic [31:0] keep [3];
    keep = '{32'h000, 32'h100, 32'h300};
    sel = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      do_req(1'b0, 32'(t) << 8, '0, '0, lat, rdat, drd, dwr, ok);
      total++; if (drd !== 1 || rdat !== pat(32'(t) << 8)) begin bad++; $display("[TB] FAIL w4_fill%0d: got rd=%0d data=%h want rd=1 data=%h", t, drd, rdat, pat(32'(t) << 8)); end
    end
    do_req(1'b0, 32'h000, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL w4_rehit_latency: got %0d want 1", lat); end
    do_req(1'b0, 32'h400, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (drd !== 1 || dwr !== 0) begin bad++; $display("[TB] FAIL w4_evict_ops: got rd=%0d wr=%0d want 1 0", drd, dwr); end
    total++; if (rdat !== pat(32'h400)) begin bad++; $display("[TB] FAIL w4_evict_rdata: got %h want %h", rdat, pat(32'h400)); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, keep[i], '0, '0, lat, rdat, drd, dwr, ok);
      total++; if (lat !== 1) begin bad++; $display("[TB] FAIL w4_keep_%h: got latency %0d want 1", keep[i], lat); end
    end
    do_req(1'b0, 32'h200, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (drd !== 1) begin bad++; $display("[TB] FAIL w4_victim_way2: got rd=%0d want 1", drd); end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_fill();
    int lat, drd, dwr, n; bit ok; logic [255:0] rdat;
    mem_hold = 1;
    addr = 32'h540; be = '0; wd = '0; wr = 1'b0; rd = 1'b1;
    n = 0;
    while (n < 20 && !pmem_read_a) begin
      @(negedge clk);
      n++;
    end
    total++; if (pmem_read_a !== 1'b1) begin bad++; $display("[TB] FAIL rif_fill_seen: got %b want 1", pmem_read_a); end
    total++; if (pmem_address_a !== 32'h540) begin bad++; $display("[TB] FAIL rif_fill_addr: got %h want 00000540", pmem_address_a); end
    rst = 1'b1;
    rd = 1'b0;
    @(negedge clk);
    total++; if (pmem_read_a !== 1'b0) begin bad++; $display("[TB] FAIL rif_pmem_read: got %b want 0", pmem_read_a); end
    total++; if (dut_a.state_q !== IDLE) begin bad++; $display("[TB] FAIL rif_state: got %0d want IDLE", dut_a.state_q); end
    rst = 1'b0;
    mem_hold = 0;
    @(negedge clk);
    do_req(1'b0, 32'h540, '0, '0, lat, rdat, drd, dwr, ok);
    total++; if (drd !== 1 || dwr !== 0) begin bad++; $display("[TB] FAIL rif_refill_ops: got rd=%0d wr=%0d want 1 0", drd, dwr); end
    total++; if (rdat !== pat(32'h540)) begin bad++; $display("[TB] FAIL rif_refill_rdata: got %h want %h", rdat, pat(32'h540)); end
  endtask

  initial begin
    $display("[TB] starting cache_sa_wb directed tests");
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_writeback();
    test_ways4();
    test_reset_in_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
